mem_stage_hs: RTL and testbench

- Parametrised successor to the pipeline memory-access stage. Adds a req/ack handshake to memory with wait states, byte lanes for any power-of-two data width, and big-endian lane steering.
- Adds a per-access timeout counter and an alignment-error path.
- Sits between the execute stage and writeback. Holds the upstream pipeline via stall_o while a memory transaction is outstanding.

---
 rtl/mem_stage_hs.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_hs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// Pipeline memory-access stage with req/ack handshake, big-endian byte lanes,
// per-access timeout and alignment-error reporting. Optional macro: MEM_STAGE_SEXT_EN.
module mem_stage_hs #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int PW      = 6,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid_i,
  input  logic            rd_i,
  input  logic            wr_i,
  input  logic            word_i,
`ifdef MEM_STAGE_SEXT_EN
  input  logic            sext_i,
`endif
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  input  logic [PW-1:0]   pass_i,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            valid_o,
  output logic [DW-1:0]   result_o,
  output logic [PW-1:0]   pass_o,
  output logic            err_o
);

  localparam int L  = DW / 8;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = 16;

  // Handshake: in REQ, mem_req_o stays high and mem_addr/we/be/wdata stay
  // stable until the cycle mem_ack_i is sampled high; rdata is valid with ack.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            word_q;
  logic [LW-1:0]   lane_q;
  logic            sext_q;
  logic [DW-1:0]   data_q;
  logic [PW-1:0]   pass_cap_q;
  logic            stall_q, req_q, we_q, valid_q, err_q;
  logic [AW-1:0]   addr_q;
  logic [L-1:0]    be_q;
  logic [DW-1:0]   wdata_q, result_q;
  logic [PW-1:0]   pass_q;

  logic [LW-1:0]   lane_in;
  logic            is_mem, misalign, sext_in;
  logic [L-1:0]    be_d;
  logic [DW-1:0]   wdata_d;
  logic [7:0]      rbyte;
  logic [DW-1:0]   load_d;

  assign lane_in  = addr_i[LW-1:0];
  assign is_mem   = rd_i | wr_i;
  assign misalign = word_i & (lane_in != '0);

`ifdef MEM_STAGE_SEXT_EN
  assign sext_in = sext_i;
`else
  assign sext_in = 1'b0;
`endif

  // Lane k lives in bits [DW-1-8k -: 8]; be bit L-1 is the lowest address.
  always_comb begin
    be_d  = '0;
    rbyte = '0;
    for (int k = 0; k < L; k++) begin
      if (word_i || (lane_in == LW'(k))) be_d[L-1-k] = 1'b1;
      if (lane_q == LW'(k)) rbyte = mem_rdata_i[DW-1-8*k -: 8];
    end
    wdata_d = word_i ? data_i : {L{data_i[7:0]}};
    load_d  = word_q ? mem_rdata_i : {{(DW-8){sext_q & rbyte[7]}}, rbyte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= 1'b0;
      lane_q     <= '0;
      sext_q     <= 1'b0;
      data_q     <= '0;
      pass_cap_q <= '0;
      stall_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      pass_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && valid_i) begin
            if (!is_mem) begin
              valid_q  <= 1'b1;
              result_q <= data_i;
              pass_q   <= pass_i;
            end else if (misalign) begin
              valid_q  <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
              pass_q   <= pass_i;
            end else begin
              state_q    <= REQ;
              cnt_q      <= '0;
              stall_q    <= 1'b1;
              req_q      <= 1'b1;
              we_q       <= wr_i & ~rd_i;
              addr_q     <= addr_i;
              be_q       <= be_d;
              wdata_q    <= wdata_d;
              word_q     <= word_i;
              lane_q     <= lane_in;
              sext_q     <= sext_in;
              data_q     <= data_i;
              pass_cap_q <= pass_i;
            end
          end
        end
        REQ: begin
          // Ack has priority over a timeout landing on the same edge.
          if (mem_ack_i || (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q  <= IDLE;
            stall_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            valid_q  <= 1'b1;
            pass_q   <= pass_cap_q;
            if (mem_ack_i) begin
              result_q <= we_q ? data_q : load_d;
            end else begin
              err_q    <= 1'b1;
              result_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o     = stall_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign result_o    = result_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs (DW=16, TIMEOUT=4).
module tb_mem_stage_hs;

  logic        clk, rst, en, valid_i, rd_i, wr_i, word_i, sext_i;
  logic [15:0] addr_i, data_i, mem_rdata_i;
  logic [5:0]  pass_i;
  logic        stall_o, mem_req_o, mem_we_o, mem_ack_i, valid_o, err_o;
  logic [15:0] mem_addr_o, mem_wdata_o, result_o;
  logic [1:0]  mem_be_o;
  logic [5:0]  pass_o;

  int checks = 0;
  int failures = 0;

  mem_stage_hs #(.DW(16), .AW(16), .PW(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .rd_i(rd_i), .wr_i(wr_i),
    .word_i(word_i),
`ifdef MEM_STAGE_SEXT_EN
    .sext_i(sext_i),
`endif
    .addr_i(addr_i), .data_i(data_i), .pass_i(pass_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .valid_o(valid_o), .result_o(result_o),
    .pass_o(pass_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic rd, input logic wr, input logic word,
                          input logic [15:0] addr, input logic [15:0] data,
                          input logic [5:0] pass);
    en = 1'b1; valid_i = 1'b1; rd_i = rd; wr_i = wr; word_i = word;
    addr_i = addr; data_i = data; pass_i = pass;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; valid_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; word_i = 1'b0;
    sext_i = 1'b0; addr_i = '0; data_i = '0; pass_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_o, err_o, stall_o, mem_req_o, mem_we_o} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000", {valid_o, err_o, stall_o, mem_req_o, mem_we_o});
    end
    checks++;
    if ({result_o, pass_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {result_o, pass_o, mem_addr_o, mem_be_o, mem_wdata_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_nonmem;
    int req_seen = 0;
    drive_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 6'h2A);
    @(negedge clk);
    if (mem_req_o) req_seen++;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== 16'hBEEF || pass_o !== 6'h2A || err_o !== 1'b0) begin
      failures++; $display("FAIL nonmem_result: got v=%b r=%h p=%h e=%b expected v=1 r=BEEF p=2A e=0", valid_o, result_o, pass_o, err_o);
    end
    @(negedge clk);
    if (mem_req_o) req_seen++;
    checks++;
    if (valid_o !== 1'b0 || req_seen !== 0) begin
      failures++; $display("FAIL nonmem_pulse: got v=%b req_seen=%0d expected v=0 req_seen=0", valid_o, req_seen);
    end
  endtask

  task automatic test_byte_read;
    int stall_cnt = 0;
    logic [15:0] exp_res;
`ifdef MEM_STAGE_SEXT_EN
    exp_res = 16'hFFF4;
`else
    exp_res = 16'h00F4;
`endif
    sext_i = 1'b1;
    drive_op(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000, 6'h15);
    @(negedge clk);
    valid_i = 1'b0; sext_i = 1'b0; pass_i = 6'h3F;
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== 2'b01 || mem_addr_o !== 16'h0101) begin
      failures++; $display("FAIL bread_req: got req=%b we=%b be=%b a=%h expected req=1 we=0 be=01 a=0101", mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (stall_o) stall_cnt++;
      if (i == 3) begin mem_ack_i = 1'b1; mem_rdata_i = 16'h12F4; end
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== exp_res || err_o !== 1'b0 || pass_o !== 6'h15) begin
      failures++; $display("FAIL bread_result: got v=%b r=%h e=%b p=%h expected v=1 r=%h e=0 p=15", valid_o, result_o, err_o, pass_o, exp_res);
    end
    checks++;
    if (stall_cnt !== 4 || stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_be_o !== 2'b00) begin
      failures++; $display("FAIL bread_stall: got stall_cycles=%0d stall=%b req=%b be=%b expected 4 0 0 00", stall_cnt, stall_o, mem_req_o, mem_be_o);
    end
  endtask

  // Ends on the valid_o cycle and accepts a new op right there.
  task automatic test_back_to_back;
    drive_op(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0077, 6'h01);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (mem_we_o !== 1'b1 || mem_be_o !== 2'b10 || mem_wdata_o !== 16'h7777 || valid_o !== 1'b0) begin
      failures++; $display("FAIL bwrite_req: got we=%b be=%b wd=%h v=%b expected we=1 be=10 wd=7777 v=0", mem_we_o, mem_be_o, mem_wdata_o, valid_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 16'hDEAD;
    @(negedge clk);
    mem_ack_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== 16'h0077 || err_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL bwrite_done: got v=%b r=%h e=%b req=%b expected v=1 r=0077 e=0 req=0", valid_o, result_o, err_o, mem_req_o);
    end
    drive_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 6'h07);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== 16'h1234 || pass_o !== 6'h07) begin
      failures++; $display("FAIL b2b_accept: got v=%b r=%h p=%h expected v=1 r=1234 p=07", valid_o, result_o, pass_o);
    end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b1, 16'h0003, 16'h5555, 6'h02);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || err_o !== 1'b1 || result_o !== 16'h0000 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL misalign: got v=%b e=%b r=%h req=%b st=%b expected v=1 e=1 r=0000 req=0 st=0", valid_o, err_o, result_o, mem_req_o, stall_o);
    end
  endtask

  task automatic test_disabled;
    en = 1'b0; valid_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; word_i = 1'b0; addr_i = 16'h0010;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL disabled: got v=%b req=%b st=%b expected 0 0 0", valid_o, mem_req_o, stall_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_timeout;
    int n = 0;
    drive_op(1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 6'h09);
    @(negedge clk);
    valid_i = 1'b0;
    while (mem_req_o === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL timeout_len: got %0d req cycles expected 4", n);
    end
    checks++;
    if (valid_o !== 1'b1 || err_o !== 1'b1 || result_o !== 16'h0000 || pass_o !== 6'h09) begin
      failures++; $display("FAIL timeout_result: got v=%b e=%b r=%h p=%h expected v=1 e=1 r=0000 p=09", valid_o, err_o, result_o, pass_o);
    end
  endtask

  task automatic test_ack_at_limit;
    drive_op(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000, 6'h0C);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (mem_be_o !== 2'b11 || mem_addr_o !== 16'h0006) begin
      failures++; $display("FAIL wread_req: got be=%b a=%h expected be=11 a=0006", mem_be_o, mem_addr_o);
    end
    repeat (3) @(negedge clk);
    mem_ack_i = 1'b1; mem_rdata_i = 16'hA5C3;
    @(negedge clk);
    mem_ack_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || err_o !== 1'b0 || result_o !== 16'hA5C3 || pass_o !== 6'h0C) begin
      failures++; $display("FAIL ack_at_limit: got v=%b e=%b r=%h p=%h expected v=1 e=0 r=A5C3 p=0C", valid_o, err_o, result_o, pass_o);
    end
  endtask

  task automatic test_reset_mid_req;
    int v_seen = 0;
    drive_op(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 6'h11);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++; $display("FAIL rstreq_pre: got req=%b expected 1", mem_req_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_be_o !== 2'b00) begin
      failures++; $display("FAIL rstreq_drop: got req=%b st=%b be=%b expected 0 0 00", mem_req_o, stall_o, mem_be_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 16'h4321;
    @(negedge clk);
    if (valid_o) v_seen++;
    rst = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    if (valid_o) v_seen++;
    checks++;
    if (v_seen !== 0) begin
      failures++; $display("FAIL rstreq_novalid: got %0d valid pulses expected 0", v_seen);
    end
    drive_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'hC0DE, 6'h33);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== 16'hC0DE || pass_o !== 6'h33) begin
      failures++; $display("FAIL rstreq_after: got v=%b r=%h p=%h expected v=1 r=C0DE p=33", valid_o, result_o, pass_o);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_byte_read();
    test_back_to_back();
    test_misalign();
    test_disabled();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_req();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
